rsa_modexp_core: RTL and testbench
==================================

# rsa_modexp_core

Bit-serial RSA modular-exponentiation engine computing cypher = indata^inExp mod inMod. It is the responder on the rsa_intf protocol: it samples `indata`, `inExp`, `inMod` on a `ds` strobe and returns `cypher` with a one-cycle `ready` pulse. The UVM driver and monitor attach to its ports unchanged. It uses left-to-right square-and-multiply built on a Blakley interleaved modular multiplier, so it needs no Montgomery constants and accepts any modulus except zero.

## Interface
- `WIDTH`, default 2048: operand width in bits; the bench also runs with 16.
- `clk` input 1: single clock, all logic on its rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `indata` input WIDTH: base; may be ≥ inMod.
- `inExp` input WIDTH: exponent.
- `inMod` input WIDTH: modulus.
- `ds` input 1: data strobe; one-cycle request.
- `cypher` output WIDTH: result; holds its value until the next completion.
- `ready` output 1: one-cycle completion pulse; `cypher` is valid in the same cycle.
- `busy` output 1: high from accept until `ready`, inclusive.

## Operation
- **States:** IDLE, SQR, MUL, DONE.
- **IDLE, `ds`=1:** latch M=inMod, B=indata, E=inExp; R = (M==1) ? 0 : 1; bit index k=WIDTH-1.
  - If M==0: go to DONE with R=0 (error result).
  - Otherwise: go to SQR.
- **SQR:** compute R = R·R mod M, then:
  - E[k]=1: go to MUL.
  - E[k]=0 and k>0: k--, stay in SQR.
  - E[k]=0 and k=0: go to DONE.
- **MUL:** compute R = B·R mod M, then k>0 → k--, SQR; k=0 → DONE.
- **DONE:** cypher ← R; `ready`=1 for one cycle; then IDLE.
- **Modular multiply X·Y mod M** (Y<M, X any value):
  - Takes exactly WIDTH cycles; scans X MSB-first.
  - Accumulator P (WIDTH+2 bits) starts at 0.
  - Each cycle: P' = 2P + x_i·Y; subtract 2M if P' ≥ 2M, else subtract M if P' ≥ M.
  - Invariant: P<M after every cycle; X is the shifted operand, Y the addend.
  - MUL uses X=B so an unreduced base is legal; SQR uses X=Y=R.
- **Ignored `ds`:** `ds` outside IDLE is dropped, not queued; this includes the DONE cycle.
- **Reset values:** `cypher`=0, `ready`=0, `busy`=0, state IDLE.
  - Reset mid-operation aborts immediately.
  - No `ready` is produced for the aborted request.

## Timing
- Let edge 0 be the `clk` edge that samples `ds`=1 in IDLE.
- Let p = popcount(inExp).
- `ready` is high in the cycle after edge N:
  - N = WIDTH·(WIDTH + p) + 1 in the default build.
  - N = 1 for M==0.
- `busy` rises after edge 0 and falls after the edge that ends the `ready` cycle.
- The next `ds` is accepted at edge N+1 at the earliest.
- `cypher` changes only at the edge that raises `ready`.
- Worst case at WIDTH=2048 (inExp all ones): 2048·4096+1 cycles.

## Configuration
- **`RSA_SKIP_LEADING_ZEROS_EN` defined:**
  - While R==1 and E[k]==0 (leading zero exponent bits), SQR spends 1 cycle instead of WIDTH and decrements k.
  - With Z = number of leading zeros of inExp: N = 1 + Z + WIDTH·(WIDTH − Z + p).
  - inExp==0 gives N = WIDTH + 1.
  - M==1 follows the normal path (R=0, so no skipping).
- **Undefined (default):** every exponent bit costs a full WIDTH-cycle square; latency as in Timing.
- The numeric result is identical in both builds.

## Test plan
- WIDTH=16, indata=4, inExp=13, inMod=497 → cypher=445.
  - `ready` after edge 305 in the default build.
  - `ready` after edge 125 with `RSA_SKIP_LEADING_ZEROS_EN`.
- WIDTH=16, unreduced base: indata=1000, inExp=1, inMod=497 → cypher=6, `ready` after edge 273 (default).
- WIDTH=16, edge cases on modulus and exponent:
  - inMod=0 → cypher=0, `ready` after edge 1.
  - inMod=1, inExp=5 → cypher=0.
  - inExp=0, inMod=497 → cypher=1.
- `ds` pulsed again at edge 50 of the 4^13 mod 497 request → ignored; a single `ready` with 445.
  - A new request after that `ready` (3^7 mod 11) → cypher=9.
- `reset` asserted at edge 100 mid-operation → outputs 0 and `busy`=0 immediately, no `ready`.
  - Fresh request after release → correct result with nominal latency.
- WIDTH=2048 random cases (odd M, random base and exponent) against a reference model → cypher matches.
  - `ready` pulse exactly one cycle wide; `busy` well-formed.

Source files
------------

// File: rtl/rsa_modexp_core.sv
// rsa_modexp_core: bit-serial modular exponentiation, cypher = indata^inExp mod inMod.
// It uses left-to-right square-and-multiply over a Blakley interleaved modular
// multiplier, so no Montgomery constants are needed. Any non-zero modulus is accepted.
// Ports:
//   clk     - clock; all logic runs on the rising edge
//   reset   - asynchronous reset, active low
//   indata  - base; may be >= inMod
//   inExp   - exponent
//   inMod   - modulus; zero yields cypher = 0
//   ds      - one-cycle request strobe; sampled only in IDLE
//   cypher  - result; held until the next completion
//   ready   - one-cycle completion pulse; cypher is valid in the same cycle
//   busy    - high from accept through the ready cycle
// Optional build macro: RSA_SKIP_LEADING_ZEROS_EN. When defined, a square of R==1
// on a zero exponent bit takes one cycle instead of WIDTH cycles.
module rsa_modexp_core #(
   parameter int unsigned WIDTH = 2048
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [WIDTH-1:0] indata,
   input  logic [WIDTH-1:0] inExp,
   input  logic [WIDTH-1:0] inMod,
   input  logic             ds,
   output logic [WIDTH-1:0] cypher,
   output logic             ready,
   output logic             busy
);

   localparam int unsigned KW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam int unsigned PW = WIDTH + 2;

   typedef enum logic [1:0] {S_IDLE, S_SQR, S_MUL, S_DONE} state_e;

   state_e           state_q, state_d;
   logic [WIDTH-1:0] m_q, m_d, b_q, b_d, e_q, e_d, r_q, r_d, x_q, x_d;
   logic [WIDTH-1:0] cypher_q, cypher_d;
   logic [PW-1:0]    p_q, p_d;
   logic [KW-1:0]    k_q, k_d, cnt_q, cnt_d;
   logic             ready_q, ready_d, busy_q, busy_d;

   logic [PW-1:0]    m1_c, m2_c, p_sum_c, p_red_c;
   logic [WIDTH-1:0] r_init_c;
   logic             mul_last_c, k_zero_c, ebit_c, skip_c;

   // One Blakley step: P' = 2P + x_i*Y, then fold back below M. P < M holds, so P' < 3M.
   assign m1_c    = PW'(m_q);
   assign m2_c    = m1_c << 1;
   assign p_sum_c = (p_q << 1) + (x_q[WIDTH-1] ? PW'(r_q) : PW'(0));

   always_comb begin
      p_red_c = p_sum_c;
      if (p_sum_c >= m2_c) begin
         p_red_c = p_sum_c - m2_c;
      end else if (p_sum_c >= m1_c) begin
         p_red_c = p_sum_c - m1_c;
      end
   end

   assign mul_last_c = (cnt_q == KW'(WIDTH - 1));
   assign k_zero_c   = (k_q == '0);
   assign ebit_c     = e_q[WIDTH-1];
   assign r_init_c   = (inMod > WIDTH'(1)) ? WIDTH'(1) : '0;

`ifdef RSA_SKIP_LEADING_ZEROS_EN
   // Squaring 1 is a no-op, so leading zero exponent bits cost one cycle each.
   assign skip_c = (cnt_q == '0) && (r_q == WIDTH'(1)) && !ebit_c;
`else
   assign skip_c = 1'b0;
`endif

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE: begin
            if (ds) begin
               state_d = (inMod == '0) ? S_DONE : S_SQR;
            end
         end
         S_SQR: begin
            if (skip_c) begin
               state_d = k_zero_c ? S_DONE : S_SQR;
            end else if (mul_last_c) begin
               if (ebit_c) begin
                  state_d = S_MUL;
               end else begin
                  state_d = k_zero_c ? S_DONE : S_SQR;
               end
            end
         end
         S_MUL: begin
            if (mul_last_c) begin
               state_d = k_zero_c ? S_DONE : S_SQR;
            end
         end
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase
   end

   // Datapath and output next values
   always_comb begin
      m_d      = m_q;
      b_d      = b_q;
      e_d      = e_q;
      r_d      = r_q;
      x_d      = x_q;
      p_d      = p_q;
      k_d      = k_q;
      cnt_d    = cnt_q;
      cypher_d = cypher_q;
      ready_d  = 1'b0;
      busy_d   = ready_q ? 1'b0 : busy_q;
      case (state_q)
         S_IDLE: begin
            if (ds) begin
               m_d    = inMod;
               b_d    = indata;
               e_d    = inExp;
               r_d    = r_init_c;
               x_d    = r_init_c;
               p_d    = '0;
               k_d    = KW'(WIDTH - 1);
               cnt_d  = '0;
               busy_d = 1'b1;
            end
         end
         S_SQR, S_MUL: begin
            if (skip_c) begin
               k_d = k_q - KW'(1);
               e_d = e_q << 1;
            end else begin
               p_d   = p_red_c;
               x_d   = x_q << 1;
               cnt_d = cnt_q + KW'(1);
               if (mul_last_c) begin
                  r_d   = p_red_c[WIDTH-1:0];
                  p_d   = '0;
                  cnt_d = '0;
                  // A set bit after the square means the next pass scans the base.
                  if ((state_q == S_SQR) && ebit_c) begin
                     x_d = b_q;
                  end else begin
                     x_d = p_red_c[WIDTH-1:0];
                     k_d = k_q - KW'(1);
                     e_d = e_q << 1;
                  end
               end
            end
         end
         S_DONE: begin
            cypher_d = r_q;
            ready_d  = 1'b1;
         end
         default: ;
      endcase
   end

   // Datapath and output registers
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q      <= '0;
         b_q      <= '0;
         e_q      <= '0;
         r_q      <= '0;
         x_q      <= '0;
         p_q      <= '0;
         k_q      <= '0;
         cnt_q    <= '0;
         cypher_q <= '0;
         ready_q  <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         m_q      <= m_d;
         b_q      <= b_d;
         e_q      <= e_d;
         r_q      <= r_d;
         x_q      <= x_d;
         p_q      <= p_d;
         k_q      <= k_d;
         cnt_q    <= cnt_d;
         cypher_q <= cypher_d;
         ready_q  <= ready_d;
         busy_q   <= busy_d;
      end
   end

   assign cypher = cypher_q;
   assign ready  = ready_q;
   assign busy   = busy_q;

endmodule

// File: tb/tb_rsa_modexp_core.sv
// Testbench for rsa_modexp_core at WIDTH=16: directed cases, modulus/exponent
// edge cases, ignored strobe, mid-operation reset, and random odd moduli
// against a reference model. Expected results go through a scoreboard queue.
module tb_rsa_modexp_core;

   localparam int unsigned W = 16;
   localparam int          BUDGET = 2000;
`ifdef RSA_SKIP_LEADING_ZEROS_EN
   localparam int          LAT_MAIN = 125;
`else
   localparam int          LAT_MAIN = 305;
`endif

   typedef struct {
      logic [W-1:0] cyp;
      int           lat;
   } exp_t;

   exp_t sb_q[$];
   int   errors = 0;
   int   checks = 0;

   logic         clk;
   logic         reset;
   logic [W-1:0] indata, inExp, inMod;
   logic         ds;
   logic [W-1:0] cypher;
   logic         ready, busy;

   rsa_modexp_core #(.WIDTH(W)) dut (
      .clk    (clk),
      .reset  (reset),
      .indata (indata),
      .inExp  (inExp),
      .inMod  (inMod),
      .ds     (ds),
      .cypher (cypher),
      .ready  (ready),
      .busy   (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #3000000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         errors++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, expv);
      end
   endtask

   // Reference: square-and-multiply plus the cycle count each step costs.
   function automatic void model(input logic [W-1:0] b, input logic [W-1:0] e,
                                 input logic [W-1:0] m, output logic [W-1:0] res,
                                 output int lat);
      longint unsigned r, bm, mm;
      int cyc;
      if (m == '0) begin
         res = '0;
         lat = 1;
         return;
      end
      mm  = 64'(m);
      bm  = 64'(b);
      r   = (m == W'(1)) ? 0 : 1;
      cyc = 0;
      for (int i = W - 1; i >= 0; i--) begin
`ifdef RSA_SKIP_LEADING_ZEROS_EN
         if (r == 1 && e[i] == 1'b0) begin
            cyc += 1;
         end else begin
            r = (r * r) % mm;
            cyc += int'(W);
         end
`else
         r = (r * r) % mm;
         cyc += int'(W);
`endif
         if (e[i]) begin
            r = (r * bm) % mm;
            cyc += int'(W);
         end
      end
      res = W'(r);
      lat = cyc + 1;
   endfunction

   // Issue one request at the next edge and follow it to completion.
   task automatic run_req(input string tag, input logic [W-1:0] b, input logic [W-1:0] e,
                          input logic [W-1:0] m, input logic [W-1:0] exp_cyp,
                          input int exp_lat, input int extra_at);
      exp_t item;
      int n, busy_low, cyp_changes;
      bit got;
      logic [W-1:0] prev;
      prev        = cypher;
      item.cyp    = exp_cyp;
      item.lat    = exp_lat;
      indata      = b;
      inExp       = e;
      inMod       = m;
      ds          = 1'b1;
      sb_q.push_back(item);
      @(posedge clk); #1;
      ds = 1'b0;
      chk({tag, " busy_after_accept"}, 64'(busy), 64'd1);
      n = 0; got = 1'b0; busy_low = 0; cyp_changes = 0;
      while (!got && n < BUDGET) begin
         ds = (n + 1 == extra_at);
         @(posedge clk); #1;
         n++;
         ds = 1'b0;
         if (ready) begin
            got = 1'b1;
         end else begin
            if (busy !== 1'b1) busy_low++;
            if (cypher !== prev) cyp_changes++;
         end
      end
      chk({tag, " ready_seen"}, 64'(got), 64'd1);
      item = sb_q.pop_front();
      chk({tag, " cypher"}, 64'(cypher), 64'(item.cyp));
      chk({tag, " latency"}, 64'(n), 64'(item.lat));
      chk({tag, " busy_in_ready"}, 64'(busy), 64'd1);
      chk({tag, " busy_low_cycles"}, 64'(busy_low), 64'd0);
      chk({tag, " early_cypher_change"}, 64'(cyp_changes), 64'd0);
      @(posedge clk); #1;
      chk({tag, " ready_width"}, 64'(ready), 64'd0);
      chk({tag, " busy_after"}, 64'(busy), 64'd0);
      chk({tag, " cypher_hold"}, 64'(cypher), 64'(item.cyp));
   endtask

   initial begin
      logic [W-1:0] rb, re, rm, rc;
      int rl, rdy_cnt;

      reset = 1'b0; ds = 1'b0; indata = '0; inExp = '0; inMod = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("reset cypher", 64'(cypher), 64'd0);
      chk("reset ready", 64'(ready), 64'd0);
      chk("reset busy", 64'(busy), 64'd0);
      reset = 1'b1;
      @(posedge clk); #1;

      run_req("4^13%497", W'(4), W'(13), W'(497), W'(445), LAT_MAIN, 0);

      model(W'(1000), W'(1), W'(497), rc, rl);
`ifndef RSA_SKIP_LEADING_ZEROS_EN
      rl = 273;
`endif
      run_req("1000^1%497", W'(1000), W'(1), W'(497), W'(6), rl, 0);

      run_req("mod0", W'(4), W'(13), W'(0), W'(0), 1, 0);
      run_req("mod1", W'(7), W'(5), W'(1), W'(0), 289, 0);

`ifdef RSA_SKIP_LEADING_ZEROS_EN
      rl = 17;
`else
      rl = 257;
`endif
      run_req("exp0", W'(5), W'(0), W'(497), W'(1), rl, 0);

      run_req("ds_ignored", W'(4), W'(13), W'(497), W'(445), LAT_MAIN, 50);
      model(W'(3), W'(7), W'(11), rc, rl);
      run_req("3^7%11", W'(3), W'(7), W'(11), W'(9), rl, 0);

      // Abort an in-flight request with reset after edge 100.
      indata = W'(4); inExp = W'(13); inMod = W'(497); ds = 1'b1;
      @(posedge clk); #1;
      ds = 1'b0;
      repeat (100) @(posedge clk);
      #1;
      reset = 1'b0;
      #1;
      chk("abort cypher", 64'(cypher), 64'd0);
      chk("abort ready", 64'(ready), 64'd0);
      chk("abort busy", 64'(busy), 64'd0);
      repeat (2) @(posedge clk);
      #1;
      reset = 1'b1;
      rdy_cnt = 0;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk); #1;
         if (ready) rdy_cnt++;
      end
      chk("abort no_ready", 64'(rdy_cnt), 64'd0);
      chk("abort busy_after", 64'(busy), 64'd0);
      run_req("after_abort", W'(4), W'(13), W'(497), W'(445), LAT_MAIN, 0);

      for (int t = 0; t < 6; t++) begin
         rb = W'($urandom);
         re = W'($urandom);
         rm = W'($urandom_range(3, 65535)) | W'(1);
         model(rb, re, rm, rc, rl);
         run_req("random", rb, re, rm, rc, rl, 0);
      end

      chk("scoreboard_empty", 64'(sb_q.size()), 64'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
